// File: rtl/rv64_decode_pkg.sv
// Shared RV64I decode definitions: opcodes, one-hot type-bit indices and the
// stored decode-buffer entry. PC is stored at its widest (64 bits); stages with
// a narrower XLEN zero-extend on store and truncate on read.
package rv64_decode_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned TYPE_W   = 12;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned PC_MAX_W = 64;

    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;

    localparam int unsigned TYPE_R       = 0;
    localparam int unsigned TYPE_R32     = 1;
    localparam int unsigned TYPE_LOAD    = 2;
    localparam int unsigned TYPE_I       = 3;
    localparam int unsigned TYPE_I32     = 4;
    localparam int unsigned TYPE_JALR    = 5;
    localparam int unsigned TYPE_STORE   = 6;
    localparam int unsigned TYPE_BRANCH  = 7;
    localparam int unsigned TYPE_LUI     = 8;
    localparam int unsigned TYPE_AUIPC   = 9;
    localparam int unsigned TYPE_JAL     = 10;
    localparam int unsigned TYPE_SHIFT_I = 11;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic [TYPE_W-1:0]   itype;
        logic                illegal;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [FUNCT3_W-1:0] funct3;
    } decode_entry_t;

endpackage

// File: rtl/instr_classifier.sv
// Combinational RV64I classifier: raw instruction word -> one-hot type vector
// and illegal flag. Type is forced to zero for illegal encodings.
// Ports: instr_i (32b word), itype_c_o (12b one-hot), illegal_c_o.
// Config: DECODE_STRICT_CHECK_EN enables funct3/funct7 legality checks;
// without it only the opcode decides legality.
module instr_classifier
    import rv64_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic [TYPE_W-1:0]  itype_c_o,
    output logic               illegal_c_o
);

    logic [OPC_W-1:0]    opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic                is_shift;
    logic                known;
    logic                fields_ok;
    logic [TYPE_W-1:0]   itype;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Opcode to type bit; shift-immediates get their own class
    always_comb begin
        itype = '0;
        known = 1'b1;
        case (opcode)
            OPC_OP:        itype[TYPE_R]      = 1'b1;
            OPC_OP_32:     itype[TYPE_R32]    = 1'b1;
            OPC_LOAD:      itype[TYPE_LOAD]   = 1'b1;
            OPC_OP_IMM: begin
                if (is_shift) itype[TYPE_SHIFT_I] = 1'b1;
                else          itype[TYPE_I]       = 1'b1;
            end
            OPC_OP_IMM_32: begin
                if (is_shift) itype[TYPE_SHIFT_I] = 1'b1;
                else          itype[TYPE_I32]     = 1'b1;
            end
            OPC_JALR:      itype[TYPE_JALR]   = 1'b1;
            OPC_STORE:     itype[TYPE_STORE]  = 1'b1;
            OPC_BRANCH:    itype[TYPE_BRANCH] = 1'b1;
            OPC_LUI:       itype[TYPE_LUI]    = 1'b1;
            OPC_AUIPC:     itype[TYPE_AUIPC]  = 1'b1;
            OPC_JAL:       itype[TYPE_JAL]    = 1'b1;
            default:       known              = 1'b0;
        endcase
    end

`ifdef DECODE_STRICT_CHECK_EN
    logic [6:0] funct7;
    logic [5:0] funct6;
    logic       f7_ok;

    assign funct7 = instr_i[31:25];
    assign funct6 = instr_i[31:26];
    // 0100000 only selects SUB / SRA variants (funct3 000 or 101)
    assign f7_ok  = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    // Field legality per opcode class
    always_comb begin
        fields_ok = 1'b1;
        case (opcode)
            OPC_OP:    fields_ok = f7_ok;
            OPC_OP_32: fields_ok = f7_ok &&
                                   ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101));
            OPC_OP_IMM: begin
                if (is_shift) fields_ok = (funct6 == 6'b000000) ||
                                          ((funct6 == 6'b010000) && (funct3 == 3'b101));
            end
            OPC_OP_IMM_32: begin
                if (is_shift) fields_ok = f7_ok && !instr_i[25];
            end
            OPC_LOAD:   fields_ok = (funct3 != 3'b111);
            OPC_STORE:  fields_ok = !funct3[2];
            OPC_BRANCH: fields_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
            OPC_JALR:   fields_ok = (funct3 == 3'b000);
            default:    fields_ok = 1'b1;
        endcase
    end
`else
    logic unused_hi;
    assign unused_hi = ^instr_i[31:15];
    assign fields_ok = 1'b1;
`endif

    assign illegal_c_o = !known || !fields_ok;
    assign itype_c_o   = illegal_c_o ? '0 : itype;

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage between fetch and the immediate extractor. Classifies each
// accepted instruction and stores the decoded entry in a 2-entry skid buffer,
// so every output (including in_ready) comes from a register.
// Ports: clk, rst_n (async active-low), flush (sync drop of everything),
// in_valid/in_ready/in_pc/in_instr (fetch side), out_valid/out_ready and the
// decoded head entry out_pc/out_instr/out_type/out_rd/out_rs1/out_rs2/
// out_funct3/out_illegal (execute side). XLEN must not exceed 64.
// Config: DECODE_STRICT_CHECK_EN (see instr_classifier).
module instr_decode_stage
    import rv64_decode_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [TYPE_W-1:0]   out_type,
    output logic [REG_W-1:0]    out_rd,
    output logic [REG_W-1:0]    out_rs1,
    output logic [REG_W-1:0]    out_rs2,
    output logic [FUNCT3_W-1:0] out_funct3,
    output logic                out_illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    state_q, state_d;
    decode_entry_t head_q, head_d;
    decode_entry_t tail_q, tail_d;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [TYPE_W-1:0] cls_type;
    logic              cls_illegal;
    decode_entry_t     new_entry;
    logic              accept;
    logic              pop;

    instr_classifier u_classifier (
        .instr_i     (in_instr),
        .itype_c_o   (cls_type),
        .illegal_c_o (cls_illegal)
    );

    // Entry built on the enqueue path
    always_comb begin
        new_entry         = '0;
        new_entry.pc      = PC_MAX_W'(in_pc);
        new_entry.instr   = in_instr;
        new_entry.itype   = cls_type;
        new_entry.illegal = cls_illegal;
        new_entry.rd      = in_instr[11:7];
        new_entry.rs1     = in_instr[19:15];
        new_entry.rs2     = in_instr[24:20];
        new_entry.funct3  = in_instr[14:12];
    end

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Occupancy FSM; head is always the oldest entry
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        head_d = new_entry;
                    end else if (accept) begin
                        tail_d  = new_entry;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State, payload and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = XLEN'(head_q.pc);
    assign out_instr   = head_q.instr;
    assign out_type    = head_q.itype;
    assign out_illegal = head_q.illegal;
    assign out_rd      = head_q.rd;
    assign out_rs1     = head_q.rs1;
    assign out_rs2     = head_q.rs2;
    assign out_funct3  = head_q.funct3;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: queue-based reference model,
// per-cycle compare process, directed literal checks and random traffic.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [11:0] out_type;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ment_t;
    ment_t mq[$];

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_type   (out_type),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_funct3 (out_funct3),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected one-hot class from the ISA tables; 0 means illegal
    function automatic logic [11:0] ref_type(input logic [31:0] w);
        logic [6:0] tab [11];
        int         idx;
        logic       ok;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       shamt_op;
        tab = '{7'h33, 7'h3B, 7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        idx = -1;
        ok  = 1'b1;
        f3  = w[14:12];
        f7  = w[31:25];
        for (int i = 0; i < 11; i++)
            if (w[6:0] == tab[i]) idx = i;
        if (idx < 0) return 12'h000;
        shamt_op = (idx == 3 || idx == 4) && (f3 == 3'd1 || f3 == 3'd5);
`ifdef DECODE_STRICT_CHECK_EN
        if (idx == 0 || idx == 1 || (idx == 4 && shamt_op))
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (idx == 1 && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ok = 1'b0;
        if (idx == 4 && shamt_op && w[25]) ok = 1'b0;
        if (idx == 3 && shamt_op)
            ok = (w[31:26] == 6'd0) || (w[31:26] == 6'h10 && f3 == 3'd5);
        if (idx == 2 && f3 == 3'd7) ok = 1'b0;
        if (idx == 6 && f3 >= 3'd4) ok = 1'b0;
        if (idx == 7 && (f3 == 3'd2 || f3 == 3'd3)) ok = 1'b0;
        if (idx == 5 && f3 != 3'd0) ok = 1'b0;
`endif
        if (!ok) return 12'h000;
        if (shamt_op) idx = 11;
        return 12'(1) << idx;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        int          r;
        ops = '{7'h33, 7'h3B, 7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        w = $urandom;
        r = int'($urandom % 8);
        if (r < 6) w[6:0] = ops[$urandom % 11];
        r = int'($urandom % 4);
        if (r == 0) w[31:25] = 7'h00;
        if (r == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    // Reference occupancy model: a FIFO of at most two entries
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            bit    acc, pp;
            ment_t e;
            acc = in_valid && (mq.size() < 2);
            pp  = out_ready && (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (pp) void'(mq.pop_front());
                if (acc) begin
                    e.pc    = in_pc;
                    e.instr = in_instr;
                    mq.push_back(e);
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, mq.size() < 2);
            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                logic [11:0] t;
                logic [31:0] w;
                w = mq[0].instr;
                t = ref_type(w);
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_instr", out_instr, w);
                chk("out_type", out_type, t);
                chk("out_illegal", out_illegal, t == 12'h000);
                chk("out_rd", out_rd, w[11:7]);
                chk("out_rs1", out_rs1, w[19:15]);
                chk("out_rs2", out_rs2, w[24:20]);
                chk("out_funct3", out_funct3, w[14:12]);
            end
        end
    end

    // Present one word with out_ready high; it must be the head one cycle later
    task automatic issue(input string name, input logic [31:0] w, input logic [11:0] et, input logic ei);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = in_pc + 64'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_instr"}, out_instr, w);
        chk({name, "_type"}, out_type, et);
        chk({name, "_illegal"}, out_illegal, ei);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got[$];
        logic [31:0] exp_bp [3];
        bit          acc;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = 64'h1000; in_instr = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_type", out_type, 12'h000);
        chk("rst_out_illegal", out_illegal, 1'b0);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_fields", {out_rd, out_rs1, out_rs2, out_funct3}, 18'h0);

        chk("model_addi", ref_type(32'h00500093), 12'h008);
        chk("model_ones", ref_type(32'hFFFFFFFF), 12'h000);

        rst_n = 1'b1;
        @(negedge clk);

        issue("addi", 32'h00500093, 12'h008, 1'b0);
        chk("addi_rd", out_rd, 5'd1);
        chk("addi_rs1", out_rs1, 5'd0);
        issue("slli", 32'h00209113, 12'h800, 1'b0);
        issue("sd", 32'h00113023, 12'h040, 1'b0);
        issue("lui", 32'h00000037, 12'h100, 1'b0);
        issue("jal", 32'h0000006F, 12'h400, 1'b0);
        issue("ones", 32'hFFFFFFFF, 12'h000, 1'b1);
        issue("zero", 32'h00000000, 12'h000, 1'b1);
`ifdef DECODE_STRICT_CHECK_EN
        issue("sll_f7", 32'h40001033, 12'h000, 1'b1);
`else
        issue("sll_f7", 32'h40001033, 12'h001, 1'b0);
`endif
        repeat (2) @(negedge clk);

        // Backpressure: three offered, two taken, third held until release
        exp_bp = '{32'h00100093, 32'h00200113, 32'h00300193};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instr = exp_bp[k];
            in_pc    = in_pc + 64'd4;
            @(negedge clk);
        end
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_head_first", out_instr, exp_bp[0]);
        @(negedge clk);
        chk("bp_head_stable", out_instr, exp_bp[0]);
        chk("bp_still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && got.size() < 3; k++) begin
            if (out_valid) got.push_back(out_instr);
            if (in_valid && in_ready) acc = 1'b1;
            @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++)
            if (k < got.size()) chk("bp_order", got[k], exp_bp[k]);
        @(negedge clk);
        chk("bp_drained", out_valid, 1'b0);

        // Flush while full with a fresh input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_instr = 32'h00000013 + 32'(k << 7);
            in_pc    = in_pc + 64'd4;
            @(negedge clk);
        end
        chk("fl_full", in_ready, 1'b0);
        in_ready_force_none: begin end
        flush    = 1'b1;
        in_instr = 32'h0000A0B7;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_no_ghost", out_valid, 1'b0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_instr = 32'h00000037 + 32'(k << 7);
            in_pc    = in_pc + 64'd4;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ar_full_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_in_ready", in_ready, 1'b1);
        chk("ar_out_instr", out_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic checked by the compare process
        for (int k = 0; k < 500; k++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            in_pc     = {$urandom, $urandom};
            in_instr  = rand_instr();
            @(negedge clk);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Pipeline stage directly upstream of the immediate extractor: accepts fetched 32-bit RV64I instructions with their PC over a valid/ready handshake, classifies each into the 12-bit one-hot instruction-type vector that the immediate extractor and the execute stage consume, and splits out register and function fields. A 2-entry skid buffer registers both outputs and `in_ready`, so timing is cut between fetch and execute. A synchronous flush empties the stage on branch redirect.

## Interface
- `XLEN`, default 64: PC width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous; drops all buffered and incoming instructions.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept; a registered signal.
- `in_pc` input XLEN: instruction address.
- `in_instr` input 32: raw instruction word.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: downstream consumes the head entry.
- `out_pc` output XLEN, `out_instr` output 32: passed through unchanged.
- `out_type` output 12: one-hot instruction class; 0 when illegal.
- `out_rd`, `out_rs1`, `out_rs2` output 5 each: `instr[11:7]`, `[19:15]`, `[24:20]`.
- `out_funct3` output 3: `instr[14:12]`.
- `out_illegal` output 1: instruction is not a supported RV64I encoding.

## Operation
- Type bits:
  - 0: OP (0110011).
  - 1: OP-32 (0111011).
  - 2: LOAD (0000011).
  - 3: OP-IMM non-shift (0010011).
  - 4: OP-IMM-32 non-shift (0011011, ADDIW).
  - 5: JALR (1100111).
  - 6: STORE (0100011).
  - 7: BRANCH (1100011).
  - 8: LUI (0110111).
  - 9: AUIPC (0010111).
  - 10: JAL (1101111).
  - 11: shift-immediate (OP-IMM or OP-IMM-32 with funct3 001/101).
- Shift-immediates set only bit 11, never bit 3 or bit 4.
- Any other opcode, including `instr[1:0]` != 11: `out_type` = 0 and `out_illegal` = 1.
- Decode is done combinationally at enqueue. The decoded fields are stored in the buffer entry, so all outputs come straight from registers.
- Buffer state machine (entry count):
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on pop without accept.
  - ONE -> FULL on accept without pop.
  - ONE stays ONE on simultaneous accept and pop.
  - FULL -> ONE on pop.
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- `in_ready` = (state != FULL). `out_valid` = (state != EMPTY).
- Ordering is strictly FIFO. The head entry's output fields are held stable while `out_valid & !out_ready`.
- `flush` has priority over everything: the next state is EMPTY and the input in the flush cycle is discarded even if `in_valid & in_ready`. A pop in the flush cycle still counts as a consumed output.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N drives `out_valid` after edge N.
- Throughput is 1 instruction/cycle with `out_ready` held high.
- `in_ready` falls one cycle after the second entry fills. There are no combinational paths from `out_ready` to `in_ready`.
- Reset values:
  - State EMPTY.
  - `out_valid` 0, `in_ready` 1.
  - `out_type` 0, `out_illegal` 0.
  - `out_pc`, `out_instr` and all field outputs 0.
- Reset asserted mid-stream discards all entries immediately (asynchronous).

## Configuration
- `DECODE_STRICT_CHECK_EN` defined: full RV64I validation; a violation sets `out_illegal` and clears `out_type`. Checks:
  - funct7 must be 0000000, or 0100000 for ADD/SUB and SRL/SRA, in OP, OP-32 and shift-W.
  - funct6 must be 000000, or 010000 for SRAI, in 64-bit shift-immediates.
  - `instr[25]` must be 0 in shift-W.
  - LOAD funct3 must not be 111.
  - STORE funct3 must be < 100.
  - BRANCH funct3 must not be 010 or 011.
  - JALR funct3 must be 000.
  - OP-32 funct3 must be in {000, 001, 101}.
- Not defined: only the opcode is checked, and funct fields are ignored for legality.

## Structure
- Shared package `rv64_decode_pkg` holds:
  - opcode constants (`OPC_LOAD`, `OPC_OP_IMM`, …);
  - type-bit index constants (`TYPE_R` = 0 … `TYPE_SHIFT_I` = 11);
  - a typedef of the stored entry (pc, instr, type, illegal, fields).
- One sub-module is natural: `instr_classifier`, pure combinational: instr in, type and illegal out. It is instantiated once on the enqueue path.
- The skid buffer and its state machine live in the top module.

## Test plan
- Reset, then with `out_ready`=1 issue the following; each must appear 1 cycle after acceptance:
  - `0x00500093` (addi x1,x0,5) -> `out_type`=0x008, `out_rd`=1, `out_rs1`=0, `out_illegal`=0.
  - `0x00209113` (slli x2,x1,2) -> 0x800.
  - `0x00113023` (sd x1,0(x2)) -> 0x040.
  - `0x00000037` -> 0x100.
  - `0x0000006F` -> 0x400.
- `0xFFFFFFFF` and `0x00000000` -> `out_type`=0, `out_illegal`=1 (both builds).
- Backpressure: hold `out_ready`=0 and offer 3 back-to-back instructions.
  - Required: `in_ready` drops after the 2nd; the 3rd is held upstream.
  - Releasing `out_ready` delivers all 3 in order with no loss or duplication.
- Flush with the buffer FULL and `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, and the flush-cycle input never appears.
- Strict build: `0x40001033` (funct7=0100000 with SLL) -> illegal. Non-strict build: same word -> `out_type`=0x001, not illegal.
- Assert `rst_n` low while FULL -> `out_valid` drops to 0 immediately, before the next clock edge.
